alu_share_arbiter: RTL and testbench

// Shares the single ALU of the multi-cycle RISC-V core between N_REQ requesters
// (e.g. PC+4 incrementer, branch-target adder, execute stage). Round-robin grant,

---
 rtl/alu_share_if.sv | 27 ++
 rtl/alu_share_arbiter.sv | 115 +++++++++++
 tb/tb_alu_share_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Requester-side bundle of the shared-ALU arbiter: request issue and response return.
// Operands, op codes and handshakes are packed per requester index.
interface alu_share_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*3-1:0]     req_op;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_zero;
  logic                   rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters.
// Each op runs IDLE (grant) -> ISSUE (ALU evaluates) -> RESP (result held until accepted).
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  alu_share_if.slave       bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic             op_legal;

  // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = PTR_W'((32'(rr_ptr) + k) % N_REQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (alu_ctrl)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state plus the combinational grant strobe (only ever high in IDLE).
  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready = N_REQ'(1) << grant_idx;
          state_nx      = ISSUE;
        end
      end
      ISSUE: state_nx = RESP;
      RESP: begin
        if (bus.rsp_ready[owner]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch on grant, result capture at end of ISSUE, release on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      owner          <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_ctrl       <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_a    <= bus.req_a[32'(grant_idx)*WIDTH +: WIDTH];
            alu_b    <= bus.req_b[32'(grant_idx)*WIDTH +: WIDTH];
            alu_ctrl <= bus.req_op[32'(grant_idx)*3 +: 3];
            owner    <= grant_idx;
            rr_ptr   <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
          end
        end
        ISSUE: begin
          bus.rsp_result <= alu_result;
          bus.rsp_zero   <= alu_zero;
          bus.rsp_err    <= !op_legal;
          bus.rsp_valid  <= N_REQ'(1) << owner;
        end
        RESP: begin
          if (bus.rsp_ready[owner]) bus.rsp_valid <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the ALU port.
module tb_alu_share_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned N_REQ = 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  int n_checks;
  int n_errors;

  alu_share_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference single-cycle ALU; unsupported codes return 0.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    bus.req_a[r*WIDTH +: WIDTH] = a;
    bus.req_b[r*WIDTH +: WIDTH] = b;
    bus.req_op[r*3 +: 3]        = op;
  endtask

  // One isolated op from requester r, starting and ending in IDLE.
  task automatic run_one(input string tag, input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] exp_res, input logic exp_z, input logic exp_err);
    logic [1:0] onehot;
    onehot = 2'b01 << r;
    set_req(r, a, b, op);
    bus.req_valid = onehot;
    #1;
    check({tag, "_grant"}, 64'(bus.req_ready), 64'(onehot));
    cycle();
    bus.req_valid = '0;
    #1;
    check({tag, "_issue_rdy"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_issue_a"}, 64'(alu_a), 64'(a));
    check({tag, "_issue_vld"}, 64'(bus.rsp_valid), 64'(0));
    cycle();
    check({tag, "_vld"}, 64'(bus.rsp_valid), 64'(onehot));
    check({tag, "_res"}, 64'(bus.rsp_result), 64'(exp_res));
    check({tag, "_zero"}, 64'(bus.rsp_zero), 64'(exp_z));
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    bus.rsp_ready = onehot;
    cycle();
    bus.rsp_ready = '0;
    check({tag, "_drop"}, 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '0;
    repeat (3) cycle();
    check("rst_rdy", 64'(bus.req_ready), 64'(0));
    check("rst_vld", 64'(bus.rsp_valid), 64'(0));
    check("rst_res", 64'(bus.rsp_result), 64'(0));
    check("rst_zero", 64'(bus.rsp_zero), 64'(0));
    check("rst_err", 64'(bus.rsp_err), 64'(0));
    check("rst_alu", 64'({alu_a, alu_ctrl}), 64'(0));
    reset = 1'b0;

    // Basic ops; rr_ptr ends at 0.
    run_one("add", 0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);
    run_one("subz", 1, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1, 1'b0);
    run_one("subneg", 1, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    set_req(0, 32'h0000_F0F0, 32'h0000_0FF0, 3'b010);
    set_req(1, 32'h0000_F000, 32'h0000_000F, 3'b011);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (i % 2 == 0) ? 32'h0000_00F0 : 32'h0000_F00F;
      #1;
      check("rr_grant", 64'(bus.req_ready), 64'(exp_g));
      cycle();
      cycle();
      check("rr_vld", 64'(bus.rsp_valid), 64'(exp_g));
      check("rr_res", 64'(bus.rsp_result), 64'(exp_r));
      cycle();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;

    // Back-pressure on req0 while req1 waits; non-owner ready is ignored.
    set_req(0, 32'd1, 32'd2, 3'b000);
    set_req(1, 32'd10, 32'd4, 3'b001);
    bus.req_valid = 2'b11;
    #1;
    check("bp_grant0", 64'(bus.req_ready), 64'(2'b01));
    cycle();
    bus.req_valid = 2'b10;
    cycle();
    bus.rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_vld", 64'(bus.rsp_valid), 64'(2'b01));
      check("bp_res", 64'(bus.rsp_result), 64'(3));
      check("bp_rdy", 64'(bus.req_ready), 64'(0));
      cycle();
    end
    bus.rsp_ready = 2'b01;
    cycle();
    bus.rsp_ready = '0;
    #1;
    check("bp_drop", 64'(bus.rsp_valid), 64'(0));
    check("bp_grant1", 64'(bus.req_ready), 64'(2'b10));
    cycle();
    bus.req_valid = '0;
    cycle();
    check("bp_vld1", 64'(bus.rsp_valid), 64'(2'b10));
    check("bp_res1", 64'(bus.rsp_result), 64'(6));
    bus.rsp_ready = 2'b10;
    cycle();
    bus.rsp_ready = '0;

    // Illegal op then SLT.
    run_one("illegal", 0, 32'd3, 32'd4, 3'b110, 32'd0, 1'b1, 1'b1);
    run_one("slt", 1, 32'd2, 32'd8, 3'b101, 32'd1, 1'b0, 1'b0);

    // Reset during ISSUE: req0 grant leaves rr_ptr=1, reset must bring it back to 0.
    set_req(0, 32'h11, 32'h22, 3'b000);
    bus.req_valid = 2'b01;
    #1;
    check("ri_grant", 64'(bus.req_ready), 64'(2'b01));
    cycle();
    bus.req_valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("ri_vld", 64'(bus.rsp_valid), 64'(0));
    check("ri_res", 64'(bus.rsp_result), 64'(0));
    check("ri_alu", 64'({alu_a, alu_b, alu_ctrl}), 64'(0));
    check("ri_rdy", 64'(bus.req_ready), 64'(0));
    cycle();
    check("ri_stray1", 64'(bus.rsp_valid), 64'(0));
    cycle();
    check("ri_stray2", 64'(bus.rsp_valid), 64'(0));
    set_req(0, 32'd4, 32'd4, 3'b001);
    bus.req_valid = 2'b11;
    #1;
    check("ri_rrptr", 64'(bus.req_ready), 64'(2'b01));

    // Reset during RESP.
    cycle();
    bus.req_valid = '0;
    cycle();
    check("rr_vld_pre", 64'(bus.rsp_valid), 64'(2'b01));
    check("rr_zero_pre", 64'(bus.rsp_zero), 64'(1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rs_vld", 64'(bus.rsp_valid), 64'(0));
    check("rs_zero", 64'(bus.rsp_zero), 64'(0));
    check("rs_alu_b", 64'(alu_b), 64'(0));
    cycle();
    check("rs_stray", 64'(bus.rsp_valid), 64'(0));
    bus.req_valid = 2'b11;
    #1;
    check("rs_rrptr", 64'(bus.req_ready), 64'(2'b01));
    cycle();
    bus.req_valid = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
